// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: one full-adder cell adds two NUM_BITS-wide
// operands LSB first, one bit per clock, and presents the sum and carry-out
// with a single-cycle done pulse.

// Single full-adder cell used as the serial datapath core.
module adder_1bit (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
endmodule

module serial_add_ctrl #(
    parameter int NUM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [NUM_BITS-1:0] a,
    input  logic [NUM_BITS-1:0] b,
    input  logic                carry_in,
    output logic                busy,
    output logic                done,
    output logic [NUM_BITS-1:0] sum,
    output logic                carry_out
);

    localparam int CW = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
    localparam logic [CW-1:0] LAST = CW'(NUM_BITS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic                busy_q;
    logic                done_q;
    logic [NUM_BITS-1:0] a_sr_q;
    logic [NUM_BITS-1:0] b_sr_q;
    logic [NUM_BITS-1:0] sum_sr_q;
    logic                carry_q;
    logic [CW-1:0]       cnt_q;
    logic [NUM_BITS-1:0] sum_q;
    logic                cout_q;

    logic load_d;
    logic step_d;
    logic add_s;
    logic add_c;

    adder_1bit u_add (
        .a_i (a_sr_q[0]),
        .b_i (b_sr_q[0]),
        .c_i (carry_q),
        .s_o (add_s),
        .c_o (add_c)
    );

    // Next-state decode: accept start only in IDLE, run NUM_BITS cycles, then one DONE cycle.
    always_comb begin
        state_d = state_q;
        load_d  = 1'b0;
        step_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    load_d  = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                step_d = 1'b1;
                if (cnt_q == LAST) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register plus registered busy/done derived from the upcoming state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != S_IDLE);
            done_q  <= (state_d == S_DONE);
        end
    end

    // Serial datapath: capture operands, shift one bit per RUN cycle, publish result on the last bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            sum_sr_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
        end else if (load_d) begin
            a_sr_q   <= a;
            b_sr_q   <= b;
            sum_sr_q <= '0;
            carry_q  <= carry_in;
            cnt_q    <= '0;
        end else if (step_d) begin
            a_sr_q   <= {1'b0, a_sr_q[NUM_BITS-1:1]};
            b_sr_q   <= {1'b0, b_sr_q[NUM_BITS-1:1]};
            sum_sr_q <= {add_s, sum_sr_q[NUM_BITS-1:1]};
            carry_q  <= add_c;
            if (cnt_q != LAST) begin
                cnt_q <= cnt_q + CW'(1);
            end else begin
                // Final bit: the visible result only ever shows a completed add.
                sum_q  <= {add_s, sum_sr_q[NUM_BITS-1:1]};
                cout_q <= add_c;
            end
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign sum       = sum_q;
    assign carry_out = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl: stimulus pushes expected results,
// a monitor pops and compares on every done pulse.
module tb_serial_add_ctrl;

    localparam int N = 8;

    typedef struct packed {
        logic [N-1:0] s;
        logic         c;
        int           cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;
    logic         carry_in = 1'b0;
    logic         busy;
    logic         done;
    logic [N-1:0] sum;
    logic         carry_out;

    serial_add_ctrl #(.NUM_BITS(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a         (a),
        .b         (b),
        .carry_in  (carry_in),
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .carry_out (carry_out)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   done_seen = 0;
    int   last_done_cyc = -1;
    bit   b2b_phase = 1'b0;
    logic done_prev = 1'b0;
    exp_t sb[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    endtask

    // Reference model: plain (N+1)-bit arithmetic.
    function automatic logic [N:0] ref_add(input logic [N-1:0] x, input logic [N-1:0] y, input logic ci);
        return {1'b0, x} + {1'b0, y} + {{N{1'b0}}, ci};
    endfunction

    // Drive one operand set at the current negedge; start accepted at the next edge.
    task automatic issue(input logic [N-1:0] x, input logic [N-1:0] y, input logic ci, input bit expect_it);
        exp_t     e;
        logic [N:0] r;
        start    = 1'b1;
        a        = x;
        b        = y;
        carry_in = ci;
        if (expect_it) begin
            r     = ref_add(x, y, ci);
            e.s   = r[N-1:0];
            e.c   = r[N];
            e.cyc = cyc + 1 + N;
            sb.push_back(e);
        end
    endtask

    task automatic wait_done(input int target);
        int t = 0;
        while (done_seen < target && t < 100) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (done_seen < target) chk("wait_done_timeout", 64'(done_seen), 64'(target));
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done) begin
            if (done_prev) chk("done_pulse_width", 64'(done_prev), 64'd0);
            if (sb.size() == 0) begin
                chk("unexpected_done", 64'(sb.size()), 64'd1);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sum", 64'(sum), 64'(e.s));
                chk("carry_out", 64'(carry_out), 64'(e.c));
                chk("done_cycle", 64'(cyc), 64'(e.cyc));
                chk("busy_at_done", 64'(busy), 64'd1);
            end
            if (b2b_phase && last_done_cyc >= 0)
                chk("done_spacing", 64'(cyc - last_done_cyc), 64'(N + 2));
            last_done_cyc = cyc;
            done_seen++;
        end
        done_prev = done;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int target;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_sum", 64'(sum), 64'd0);
        chk("rst_cout", 64'(carry_out), 64'd0);

        // Basic add, full wrap-around.
        issue(8'h0F, 8'h01, 1'b0, 1'b1);
        @(negedge clk); start = 1'b0;
        wait_done(1);
        @(negedge clk);
        issue(8'hFF, 8'h01, 1'b0, 1'b1);
        @(negedge clk); start = 1'b0;
        wait_done(2);

        // All ones with carry in; busy must stay high N+1 cycles.
        @(negedge clk);
        issue(8'hFF, 8'hFF, 1'b1, 1'b1);
        for (int i = 1; i <= N + 2; i++) begin
            @(negedge clk);
            start = 1'b0;
            chk($sformatf("busy_len_%0d", i), 64'(busy), 64'(i <= N + 1));
        end
        wait_done(3);

        // Start mid-RUN is ignored; start the cycle after done is accepted.
        @(negedge clk);
        issue(8'h5A, 8'h3C, 1'b1, 1'b1);
        @(negedge clk); start = 1'b0; a = 8'hAA; b = 8'h55;
        repeat (2) @(negedge clk);
        issue(8'h00, 8'h00, 1'b0, 1'b0);
        @(negedge clk); start = 1'b0;
        wait_done(4);
        @(negedge clk);
        issue(8'h81, 8'h7F, 1'b0, 1'b1);
        @(negedge clk); start = 1'b0;
        wait_done(5);

        // Reset during the 4th RUN cycle discards the add.
        @(negedge clk);
        issue(8'h12, 8'h34, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        start = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrun_rst_busy", 64'(busy), 64'd0);
        chk("midrun_rst_done", 64'(done), 64'd0);
        chk("midrun_rst_sum", 64'(sum), 64'd0);
        chk("midrun_rst_cout", 64'(carry_out), 64'd0);
        repeat (15) @(negedge clk);
        chk("no_done_after_rst", 64'(done_seen), 64'd5);

        // Back-to-back random adds with start held high; operands scrambled between captures.
        b2b_phase = 1'b1;
        last_done_cyc = -1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            issue(N'($urandom), N'($urandom), 1'($urandom), 1'b1);
            repeat (N + 1) begin
                @(negedge clk);
                a        = N'($urandom);
                b        = N'($urandom);
                carry_in = 1'($urandom);
            end
        end
        @(negedge clk);
        start = 1'b0;
        target = 5 + 1000;
        wait_done(target);
        repeat (12) @(negedge clk);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        chk("total_done", 64'(done_seen), 64'(target));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
